// File: rtl/ddr3_cmd_pkg.sv
// Command encodings, tag entry layout and small helpers shared by the DDR3 host arbiter.
package ddr3_cmd_pkg;

  localparam logic [2:0] CMD_SCR = 3'd1;
  localparam logic [2:0] CMD_SCW = 3'd2;
  localparam logic [2:0] CMD_BLR = 3'd3;
  localparam logic [2:0] CMD_BLW = 3'd4;
  localparam logic [2:0] CMD_ATR = 3'd5;
  localparam logic [2:0] CMD_ATW = 3'd6;

  localparam int IN_DEPTH = 32;

  typedef struct packed {
    logic       id;
    logic [4:0] beats_m1;
  } tag_t;

  function automatic logic is_cmd(input logic [2:0] cmd);
    return (cmd != 3'd0) && (cmd != 3'd7);
  endfunction

  function automatic logic is_write(input logic [2:0] cmd);
    return (cmd == CMD_SCW) || (cmd == CMD_BLW) || (cmd == CMD_ATR) || (cmd == CMD_ATW);
  endfunction

  function automatic logic is_read(input logic [2:0] cmd);
    return (cmd == CMD_SCR) || (cmd == CMD_BLR) || (cmd == CMD_ATR);
  endfunction

  // Number of return words a read-type command produces; zero for pure writes.
  function automatic logic [5:0] beats_for(input logic [2:0] cmd, input logic [1:0] sz);
    logic [5:0] n;
    n = 6'd0;
    if (cmd == CMD_SCR || cmd == CMD_ATR) n = 6'd1;
    else if (cmd == CMD_BLR) n = {1'b0, sz, 3'b000} + 6'd8;
    return n;
  endfunction

endpackage

// File: rtl/ddr3_tag_fifo.sv
// In-order queue of outstanding reads; the head entry counts down its return beats in place.
module ddr3_tag_fifo
  import ddr3_cmd_pkg::*;
#(
  parameter int TAG_DEPTH_P2 = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  tag_t push_data,
  input  logic dec,
  output logic head_id,
  output logic full,
  output logic empty
);

  localparam int DEPTH = 1 << TAG_DEPTH_P2;
  localparam int PW    = TAG_DEPTH_P2;
  localparam int CW    = TAG_DEPTH_P2 + 1;

  tag_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_dec;
  logic          do_pop;

  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    head_id = mem[rd_ptr].id;
    do_push = push && !full;
    do_dec  = dec && !empty;
    do_pop  = do_dec && (mem[rd_ptr].beats_m1 == 5'd0);
  end

  // Push and head update never target the same slot: a full queue refuses pushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_dec && !do_pop) mem[rd_ptr].beats_m1 <= mem[rd_ptr].beats_m1 - 5'd1;
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ddr3_host_arbiter.sv
// Two-requester round-robin front end for ddr3_controller with BLW burst lock and in-order read return steering.
module ddr3_host_arbiter #(
  parameter int TAG_DEPTH_P2 = 3,
  parameter int IN_DEPTH     = ddr3_cmd_pkg::IN_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  input  logic [2:0]  req_cmd_0,
  input  logic [2:0]  req_cmd_1,
  input  logic [25:0] req_addr_0,
  input  logic [25:0] req_addr_1,
  input  logic [1:0]  req_sz_0,
  input  logic [1:0]  req_sz_1,
  input  logic [2:0]  req_op_0,
  input  logic [2:0]  req_op_1,
  input  logic [15:0] req_din_0,
  input  logic [15:0] req_din_1,
  output logic        req_gnt_0,
  output logic        req_gnt_1,
  output logic        req_wready_0,
  output logic        req_wready_1,
  output logic        req_rvalid_0,
  output logic        req_rvalid_1,
  output logic [15:0] req_rdata,
  output logic [25:0] req_raddr,
  output logic [2:0]  cmd,
  output logic [25:0] addr,
  output logic [1:0]  sz,
  output logic [2:0]  op,
  output logic [15:0] din,
  output logic        read,
  input  logic        notfull,
  input  logic [5:0]  fillcount,
  input  logic        validout,
  input  logic [15:0] dout,
  input  logic [25:0] raddr
);
  import ddr3_cmd_pkg::*;

  typedef enum logic {IDLE, BURST} state_e;

  state_e      state, state_nx;
  logic        owner, owner_nx;
  logic        rr_last, rr_last_nx;
  logic [4:0]  beats_left, beats_left_nx;
  logic [1:0]  cand, gnt, wready;
  logic        win, in_full;
  logic [2:0]  w_cmd;
  logic [1:0]  w_sz;
  logic        push, dec, tag_full, tag_empty, head_id;
  tag_t        push_data;

  ddr3_tag_fifo #(.TAG_DEPTH_P2(TAG_DEPTH_P2)) u_tags (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .dec       (dec),
    .head_id   (head_id),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  // Everything is gated by reset so outputs are quiet in the reset cycle itself.
  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    rr_last_nx    = rr_last;
    beats_left_nx = beats_left;
    gnt           = '0;
    wready        = '0;
    cmd           = '0;
    addr          = '0;
    sz            = '0;
    op            = '0;
    din           = '0;
    push          = 1'b0;
    push_data     = '0;
    in_full       = (fillcount == 6'(IN_DEPTH));
    cand[0] = is_cmd(req_cmd_0) && ready && notfull && (!is_write(req_cmd_0) || !in_full)
              && (!is_read(req_cmd_0) || !tag_full);
    cand[1] = is_cmd(req_cmd_1) && ready && notfull && (!is_write(req_cmd_1) || !in_full)
              && (!is_read(req_cmd_1) || !tag_full);
    win     = (cand == 2'b11) ? ~rr_last : cand[1];
    w_cmd   = win ? req_cmd_1 : req_cmd_0;
    w_sz    = win ? req_sz_1 : req_sz_0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (cand != 2'b00) begin
            gnt[win]   = 1'b1;
            cmd        = w_cmd;
            addr       = win ? req_addr_1 : req_addr_0;
            sz         = w_sz;
            op         = win ? req_op_1 : req_op_0;
            din        = win ? req_din_1 : req_din_0;
            rr_last_nx = win;
            if (is_read(w_cmd)) begin
              push               = 1'b1;
              push_data.id       = win;
              push_data.beats_m1 = 5'(beats_for(w_cmd, w_sz) - 6'd1);
            end
            if (w_cmd == CMD_BLW) begin
              state_nx      = BURST;
              owner_nx      = win;
              beats_left_nx = {w_sz, 3'b111};
            end
          end
        end
        BURST: begin
          din           = owner ? req_din_1 : req_din_0;
          wready[owner] = !in_full;
          if (!in_full) begin
            beats_left_nx = beats_left - 5'd1;
            if (beats_left == 5'd1) state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      rr_last    <= 1'b1;
      beats_left <= '0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      rr_last    <= rr_last_nx;
      beats_left <= beats_left_nx;
    end
  end

  // Return words cannot be stalled, so each one is steered straight to the head tag's owner.
  always_comb begin
    dec          = validout && !tag_empty && !reset;
    read         = !tag_empty && !reset;
    req_rvalid_0 = dec && !head_id;
    req_rvalid_1 = dec && head_id;
    req_rdata    = dec ? dout : '0;
    req_raddr    = dec ? raddr : '0;
    req_gnt_0    = gnt[0];
    req_gnt_1    = gnt[1];
    req_wready_0 = wready[0];
    req_wready_1 = wready[1];
  end

`ifndef SYNTHESIS
  assert property (@(posedge clk) disable iff (reset) !(validout && tag_empty))
    else $error("validout with no outstanding read");
`endif

endmodule

// File: tb/tb_ddr3_host_arbiter.sv
// Self-checking bench for ddr3_host_arbiter: grant vector table, burst sequences and a return-path scoreboard.
`timescale 1ns/1ps
module tb_ddr3_host_arbiter;
  import ddr3_cmd_pkg::*;

  logic        clk = 1'b0;
  logic        reset, ready, notfull, validout;
  logic [2:0]  req_cmd_0, req_cmd_1, req_op_0, req_op_1;
  logic [25:0] req_addr_0, req_addr_1;
  logic [1:0]  req_sz_0, req_sz_1;
  logic [15:0] req_din_0, req_din_1, dout;
  logic [5:0]  fillcount;
  logic [25:0] raddr;
  logic        req_gnt_0, req_gnt_1, req_wready_0, req_wready_1, req_rvalid_0, req_rvalid_1;
  logic [15:0] req_rdata, din;
  logic [25:0] req_raddr, addr;
  logic [2:0]  cmd, op;
  logic [1:0]  sz;
  logic        read;

  localparam logic [25:0] ADDR0 = 26'h0ABCDEF;
  localparam logic [25:0] ADDR1 = 26'h1234567;
  localparam logic [15:0] DIN0  = 16'hA000;
  localparam logic [15:0] DIN1  = 16'hB111;

  int   checks = 0;
  int   failures = 0;
  logic exp_id_q[$];

  typedef struct {
    logic [2:0]  c0, c1;
    logic [5:0]  fill;
    logic        nf, rdy;
    logic        g0, g1;
    logic [2:0]  ecmd;
    logic [25:0] eaddr;
    logic [15:0] edin;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  ddr3_host_arbiter dut (
    .clk(clk), .reset(reset), .ready(ready),
    .req_cmd_0(req_cmd_0), .req_cmd_1(req_cmd_1),
    .req_addr_0(req_addr_0), .req_addr_1(req_addr_1),
    .req_sz_0(req_sz_0), .req_sz_1(req_sz_1),
    .req_op_0(req_op_0), .req_op_1(req_op_1),
    .req_din_0(req_din_0), .req_din_1(req_din_1),
    .req_gnt_0(req_gnt_0), .req_gnt_1(req_gnt_1),
    .req_wready_0(req_wready_0), .req_wready_1(req_wready_1),
    .req_rvalid_0(req_rvalid_0), .req_rvalid_1(req_rvalid_1),
    .req_rdata(req_rdata), .req_raddr(req_raddr),
    .cmd(cmd), .addr(addr), .sz(sz), .op(op), .din(din), .read(read),
    .notfull(notfull), .fillcount(fillcount), .validout(validout),
    .dout(dout), .raddr(raddr)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic clearInputs();
    ready = 1'b1; notfull = 1'b1; fillcount = 6'd0; validout = 1'b0;
    dout = '0; raddr = '0;
    req_cmd_0 = '0; req_cmd_1 = '0; req_addr_0 = ADDR0; req_addr_1 = ADDR1;
    req_sz_0 = '0; req_sz_1 = '0; req_op_0 = '0; req_op_1 = '0;
    req_din_0 = DIN0; req_din_1 = DIN1;
  endtask

  task automatic doReset();
    nextCycle();
    clearInputs();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    exp_id_q.delete();
  endtask

  task automatic applyStimulus(input vec_t v);
    nextCycle();
    req_cmd_0 = v.c0; req_cmd_1 = v.c1; fillcount = v.fill; notfull = v.nf; ready = v.rdy;
    req_sz_0 = 2'd2; req_op_0 = 3'd5; req_sz_1 = 2'd1; req_op_1 = 3'd3;
  endtask

  // Checks one return word against the id expected at the head of the scoreboard.
  task automatic checkReturn(input string tag, input logic [15:0] d, input logic [25:0] a);
    logic exp_id;
    if (exp_id_q.size() == 0) begin
      checks++; failures++;
      $display("[TB] FAIL %s scoreboard: got a return word, expected none", tag);
    end else begin
      exp_id = exp_id_q.pop_front();
      checkOutput({tag, " rvalid0"}, 32'(req_rvalid_0), 32'(!exp_id));
      checkOutput({tag, " rvalid1"}, 32'(req_rvalid_1), 32'(exp_id));
      checkOutput({tag, " rdata"}, 32'(req_rdata), 32'(d));
      checkOutput({tag, " raddr"}, 32'(req_raddr), 32'(a));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int beats, k;
    logic [1:0] esz;
    logic [2:0] eop;

    vecs[0] = '{CMD_SCW, CMD_SCW, 6'd0,  1'b1, 1'b1, 1'b1, 1'b0, CMD_SCW, ADDR0, DIN0};
    vecs[1] = '{CMD_SCW, CMD_SCW, 6'd0,  1'b1, 1'b1, 1'b0, 1'b1, CMD_SCW, ADDR1, DIN1};
    vecs[2] = '{CMD_SCW, CMD_SCW, 6'd0,  1'b1, 1'b0, 1'b0, 1'b0, 3'd0,    26'd0, 16'd0};
    vecs[3] = '{CMD_SCW, CMD_SCW, 6'd0,  1'b0, 1'b1, 1'b0, 1'b0, 3'd0,    26'd0, 16'd0};
    vecs[4] = '{CMD_SCW, CMD_SCW, 6'd32, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0,    26'd0, 16'd0};
    vecs[5] = '{3'd0,    CMD_SCW, 6'd31, 1'b1, 1'b1, 1'b0, 1'b1, CMD_SCW, ADDR1, DIN1};
    vecs[6] = '{3'd7,    CMD_ATW, 6'd0,  1'b1, 1'b1, 1'b0, 1'b1, CMD_ATW, ADDR1, DIN1};
    vecs[7] = '{CMD_ATW, CMD_SCW, 6'd0,  1'b1, 1'b1, 1'b1, 1'b0, CMD_ATW, ADDR0, DIN0};

    clearInputs();
    reset = 1'b1;

    // Reset cycle: requests present but nothing may be granted.
    nextCycle();
    req_cmd_0 = CMD_SCW; req_cmd_1 = CMD_SCW;
    settle();
    checkOutput("rst gnt0", 32'(req_gnt_0), 0);
    checkOutput("rst gnt1", 32'(req_gnt_1), 0);
    checkOutput("rst cmd", 32'(cmd), 0);
    nextCycle();
    reset = 1'b0;
    clearInputs();
    settle();
    checkOutput("idle cmd", 32'(cmd), 0);
    checkOutput("idle addr", 32'(addr), 0);
    checkOutput("idle din", 32'(din), 0);
    checkOutput("idle read", 32'(read), 0);
    checkOutput("idle wready", 32'({req_wready_0, req_wready_1}), 0);
    checkOutput("idle rvalid", 32'({req_rvalid_0, req_rvalid_1}), 0);

    // Grant table.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      settle();
      esz = vecs[i].g0 ? 2'd2 : (vecs[i].g1 ? 2'd1 : 2'd0);
      eop = vecs[i].g0 ? 3'd5 : (vecs[i].g1 ? 3'd3 : 3'd0);
      checkOutput($sformatf("vec%0d gnt0", i), 32'(req_gnt_0), 32'(vecs[i].g0));
      checkOutput($sformatf("vec%0d gnt1", i), 32'(req_gnt_1), 32'(vecs[i].g1));
      checkOutput($sformatf("vec%0d cmd", i), 32'(cmd), 32'(vecs[i].ecmd));
      checkOutput($sformatf("vec%0d addr", i), 32'(addr), 32'(vecs[i].eaddr));
      checkOutput($sformatf("vec%0d din", i), 32'(din), 32'(vecs[i].edin));
      checkOutput($sformatf("vec%0d sz", i), 32'(sz), 32'(esz));
      checkOutput($sformatf("vec%0d op", i), 32'(op), 32'(eop));
    end

    // BLW sz=1 from requester 0 holds off requester 1's SCR for the whole burst.
    doReset();
    req_cmd_0 = CMD_BLW; req_sz_0 = 2'd1; req_din_0 = 16'hC000; req_cmd_1 = CMD_SCR;
    settle();
    checkOutput("blw gnt0", 32'(req_gnt_0), 1);
    checkOutput("blw gnt1", 32'(req_gnt_1), 0);
    checkOutput("blw cmd", 32'(cmd), 32'(CMD_BLW));
    checkOutput("blw din", 32'(din), 32'h0000C000);
    nextCycle();
    req_cmd_0 = 3'd0;
    for (int i = 1; i <= 15; i++) begin
      req_din_0 = 16'hC000 + 16'(i);
      settle();
      checkOutput($sformatf("blw beat%0d cmd", i), 32'(cmd), 0);
      checkOutput($sformatf("blw beat%0d wready0", i), 32'(req_wready_0), 1);
      checkOutput($sformatf("blw beat%0d gnt1", i), 32'(req_gnt_1), 0);
      checkOutput($sformatf("blw beat%0d din", i), 32'(din), 32'(16'hC000 + 16'(i)));
      nextCycle();
    end
    settle();
    checkOutput("blw after gnt1", 32'(req_gnt_1), 1);
    checkOutput("blw after cmd", 32'(cmd), 32'(CMD_SCR));
    checkOutput("blw after addr", 32'(addr), 32'(ADDR1));

    // Same burst with the data FIFO full for three cycles in the middle.
    doReset();
    req_cmd_0 = CMD_BLW; req_sz_0 = 2'd1;
    settle();
    checkOutput("stall gnt0", 32'(req_gnt_0), 1);
    nextCycle();
    req_cmd_0 = 3'd0;
    beats = 0;
    k = 0;
    while (beats < 15 && k < 40) begin
      fillcount = (k >= 4 && k < 7) ? 6'd32 : 6'd0;
      req_din_0 = 16'hD000 + 16'(beats);
      settle();
      checkOutput($sformatf("stall c%0d wready0", k), 32'(req_wready_0), 32'(fillcount != 6'd32));
      if (req_wready_0) beats++;
      k++;
      nextCycle();
    end
    fillcount = 6'd0;
    checkOutput("stall beats", 32'(beats), 15);
    checkOutput("stall cycles", 32'(k), 18);
    req_cmd_0 = CMD_SCW;
    settle();
    checkOutput("stall idle gnt0", 32'(req_gnt_0), 1);

    // BLR sz=0 from requester 1 then SCR from requester 0; returns steered in order.
    doReset();
    req_cmd_1 = CMD_BLR; req_sz_1 = 2'd0;
    settle();
    checkOutput("ret gnt1", 32'(req_gnt_1), 1);
    for (int i = 0; i < 8; i++) exp_id_q.push_back(1'b1);
    nextCycle();
    req_cmd_1 = 3'd0; req_cmd_0 = CMD_SCR;
    settle();
    checkOutput("ret gnt0", 32'(req_gnt_0), 1);
    exp_id_q.push_back(1'b0);
    nextCycle();
    req_cmd_0 = 3'd0;
    settle();
    checkOutput("ret read", 32'(read), 1);
    for (int i = 0; i < 10; i++) begin
      nextCycle();
      if (i == 4) begin
        validout = 1'b0;
        settle();
        checkOutput("ret gap rvalid", 32'({req_rvalid_0, req_rvalid_1}), 0);
        checkOutput("ret gap read", 32'(read), 1);
      end else begin
        validout = 1'b1; dout = 16'h5000 + 16'(i); raddr = 26'h300 + 26'(i);
        settle();
        checkOutput($sformatf("ret w%0d read", i), 32'(read), 1);
        checkReturn($sformatf("ret w%0d", i), 16'h5000 + 16'(i), 26'h300 + 26'(i));
      end
    end
    nextCycle();
    validout = 1'b0;
    settle();
    checkOutput("ret drained read", 32'(read), 0);
    checkOutput("ret scoreboard left", 32'(exp_id_q.size()), 0);

    // Eight SCRs fill the tag queue; the ninth waits for the first return.
    doReset();
    req_cmd_0 = CMD_SCR;
    for (int i = 0; i < 8; i++) begin
      settle();
      checkOutput($sformatf("full fill%0d gnt0", i), 32'(req_gnt_0), 1);
      exp_id_q.push_back(1'b0);
      nextCycle();
    end
    for (int i = 0; i < 2; i++) begin
      settle();
      checkOutput($sformatf("full hold%0d gnt0", i), 32'(req_gnt_0), 0);
      nextCycle();
    end
    validout = 1'b1; dout = 16'h7000; raddr = 26'h700;
    settle();
    checkOutput("full pop gnt0", 32'(req_gnt_0), 0);
    checkReturn("full pop", 16'h7000, 26'h700);
    nextCycle();
    validout = 1'b0;
    settle();
    checkOutput("full ninth gnt0", 32'(req_gnt_0), 1);
    exp_id_q.push_back(1'b0);
    nextCycle();
    req_cmd_0 = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      validout = 1'b1; dout = 16'h7000 + 16'(i); raddr = 26'h700 + 26'(i);
      settle();
      checkReturn($sformatf("full drain%0d", i), 16'h7000 + 16'(i), 26'h700 + 26'(i));
      nextCycle();
    end
    validout = 1'b0;
    settle();
    checkOutput("full drained read", 32'(read), 0);

    // Reset in the middle of a burst with three reads outstanding.
    doReset();
    req_cmd_1 = CMD_SCR;
    for (int i = 0; i < 3; i++) begin
      settle();
      checkOutput($sformatf("mid scr%0d gnt1", i), 32'(req_gnt_1), 1);
      nextCycle();
    end
    req_cmd_1 = 3'd0; req_cmd_0 = CMD_BLW; req_sz_0 = 2'd0;
    settle();
    checkOutput("mid blw gnt0", 32'(req_gnt_0), 1);
    nextCycle();
    req_cmd_0 = 3'd0;
    for (int i = 0; i < 2; i++) begin
      settle();
      checkOutput($sformatf("mid beat%0d wready0", i), 32'(req_wready_0), 1);
      nextCycle();
    end
    reset = 1'b1; req_cmd_1 = CMD_SCW;
    settle();
    checkOutput("mid rst wready0", 32'(req_wready_0), 0);
    checkOutput("mid rst gnt1", 32'(req_gnt_1), 0);
    checkOutput("mid rst read", 32'(read), 0);
    nextCycle();
    reset = 1'b0;
    clearInputs();
    settle();
    checkOutput("mid post gnt", 32'({req_gnt_0, req_gnt_1}), 0);
    checkOutput("mid post wready", 32'({req_wready_0, req_wready_1}), 0);
    checkOutput("mid post rvalid", 32'({req_rvalid_0, req_rvalid_1}), 0);
    checkOutput("mid post read", 32'(read), 0);
    checkOutput("mid post cmd", 32'(cmd), 0);
    checkOutput("mid post din", 32'(din), 0);
    checkOutput("mid post addr", 32'(addr), 0);
    req_cmd_0 = CMD_SCW;
    settle();
    checkOutput("mid idle gnt0", 32'(req_gnt_0), 1);
    checkOutput("mid idle cmd", 32'(cmd), 32'(CMD_SCW));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
